// File: rtl/io_pkg.sv
// Shared definitions for the CPU I/O port: default word width, input FSM
// encodings and the opcode/funk decode used by the `in`/`out` instructions.
package io_pkg;

    localparam int DATA_W_DEF = 16;

    // Input holding register state
    typedef enum logic {
        IN_EMPTY = 1'b0,
        IN_FULL  = 1'b1
    } inState_t;

    // I/O instruction encoding: one opcode, funk selects the direction
    localparam logic [3:0] IO_OPCODE = 4'b1100;
    localparam logic [3:0] FUNK_IN   = 4'd1;

    // Any funk value other than FUNK_IN under IO_OPCODE is an `out`
    function automatic logic isInFunk(input logic [3:0] funk);
        return funk == FUNK_IN;
    endfunction

endpackage

// File: rtl/io_port_unit_if.sv
// Device-side handshake bundle: output stream (unit -> device) and input
// stream (device -> unit), each with valid/ready.
interface io_port_unit_if #(
    parameter int DATA_W = io_pkg::DATA_W_DEF
);
    logic [DATA_W-1:0] ext_out_data;
    logic              ext_out_valid;
    logic              ext_out_ready;
    logic [DATA_W-1:0] ext_in_data;
    logic              ext_in_valid;
    logic              ext_in_ready;

    // The I/O unit side
    modport master (
        output ext_out_data, ext_out_valid, ext_in_ready,
        input  ext_out_ready, ext_in_data, ext_in_valid
    );

    // The external device side
    modport slave (
        input  ext_out_data, ext_out_valid, ext_in_ready,
        output ext_out_ready, ext_in_data, ext_in_valid
    );
endinterface

// File: rtl/io_out_fifo.sv
// First-word-fall-through output FIFO. A push while full is accepted only if
// a pop happens in the same cycle; otherwise it is dropped and flagged.
module io_out_fifo #(
    parameter int DATA_W    = io_pkg::DATA_W_DEF,
    parameter int OUT_DEPTH = 4
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] head,
    output logic              empty,
    output logic              full,
    output logic              drop
);
    localparam int PTR_W = $clog2(OUT_DEPTH);

    logic [DATA_W-1:0] mem [OUT_DEPTH];
    logic [PTR_W-1:0]  wrPtrReg;
    logic [PTR_W-1:0]  rdPtrReg;
    logic [PTR_W:0]    countReg;
    logic              popOk;
    logic              pushOk;

    assign empty  = (countReg == '0);
    assign full   = (countReg == (PTR_W+1)'(OUT_DEPTH));
    assign popOk  = pop & ~empty;
    assign pushOk = push & (~full | popOk);
    assign drop   = push & full & ~popOk;
    assign head   = mem[rdPtrReg];

    // Storage entries, cleared on reset so the head reads 0 when empty
    generate
        for (genvar gi = 0; gi < OUT_DEPTH; gi++) begin : gEntry
            always_ff @(posedge CLK or posedge Reset) begin
                if (Reset)
                    mem[gi] <= '0;
                else if (pushOk && (wrPtrReg == PTR_W'(gi)))
                    mem[gi] <= push_data;
            end
        end
    endgenerate

    // Pointers wrap naturally since OUT_DEPTH is a power of two
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            wrPtrReg <= '0;
            rdPtrReg <= '0;
            countReg <= '0;
        end else begin
            if (pushOk)
                wrPtrReg <= wrPtrReg + 1'b1;
            if (popOk)
                rdPtrReg <= rdPtrReg + 1'b1;
            case ({pushOk, popOk})
                2'b10:   countReg <= countReg + 1'b1;
                2'b01:   countReg <= countReg - 1'b1;
                default: countReg <= countReg;
            endcase
        end
    end

endmodule

// File: rtl/io_port_unit.sv
// CPU I/O responder: buffers `out` words toward the device and holds one
// device word for the next `in` instruction.
module io_port_unit
    import io_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DEF,
    parameter int OUT_DEPTH = 4
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic              OutputWrite,
    input  logic [DATA_W-1:0] out_data,
    input  logic              InputRead,
    output logic [DATA_W-1:0] in_data,
    output logic              in_valid,
    output logic              out_full,
    output logic              out_overflow,
    output logic              in_underflow,
    io_port_unit_if.master    devIf
);
    inState_t          inStateReg;
    inState_t          inStateNext;
    logic [DATA_W-1:0] heldDataReg;
    logic              overflowReg;
    logic              underflowReg;
    logic              fifoEmpty;
    logic              fifoDrop;
    logic              fifoPop;

    assign fifoPop = ~fifoEmpty & devIf.ext_out_ready;

    io_out_fifo #(
        .DATA_W    (DATA_W),
        .OUT_DEPTH (OUT_DEPTH)
    ) uOutFifo (
        .CLK       (CLK),
        .Reset     (Reset),
        .push      (OutputWrite),
        .push_data (out_data),
        .pop       (fifoPop),
        .head      (devIf.ext_out_data),
        .empty     (fifoEmpty),
        .full      (out_full),
        .drop      (fifoDrop)
    );

    assign devIf.ext_out_valid = ~fifoEmpty;
    assign out_overflow        = overflowReg;
    assign in_underflow        = underflowReg;

    // Input FSM state register
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset)
            inStateReg <= IN_EMPTY;
        else
            inStateReg <= inStateNext;
    end

    // Input FSM next state: capture when empty, release on InputRead
    always_comb begin
        inStateNext = inStateReg;
        case (inStateReg)
            IN_EMPTY: if (devIf.ext_in_valid) inStateNext = IN_FULL;
            IN_FULL:  if (InputRead)          inStateNext = IN_EMPTY;
            default:  inStateNext = IN_EMPTY;
        endcase
    end

    // Input FSM outputs: data is forced to 0 whenever nothing is held
    always_comb begin
        devIf.ext_in_ready = 1'b0;
        in_valid           = 1'b0;
        in_data            = '0;
        case (inStateReg)
            IN_EMPTY: devIf.ext_in_ready = 1'b1;
            IN_FULL: begin
                in_valid = 1'b1;
                in_data  = heldDataReg;
            end
            default: devIf.ext_in_ready = 1'b1;
        endcase
    end

    // Holding register: load on capture, clear when the word is consumed
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset)
            heldDataReg <= '0;
        else if (inStateReg == IN_EMPTY && devIf.ext_in_valid)
            heldDataReg <= devIf.ext_in_data;
        else if (inStateReg == IN_FULL && InputRead)
            heldDataReg <= '0;
    end

    // Sticky error flags, cleared only by Reset
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            overflowReg  <= 1'b0;
            underflowReg <= 1'b0;
        end else begin
            if (fifoDrop)
                overflowReg <= 1'b1;
            if (InputRead && inStateReg == IN_EMPTY)
                underflowReg <= 1'b1;
        end
    end

endmodule

// File: tb/tb_io_port_unit.sv
// Scoreboard bench for io_port_unit: stimulus pushes expected words into
// queues, a monitor pops and compares on every device-side/CPU-side transfer.
module tb_io_port_unit;
    localparam int DATA_W = 16;

    logic              CLK = 1'b0;
    logic              Reset = 1'b1;
    logic              OutputWrite = 1'b0;
    logic [DATA_W-1:0] out_data = '0;
    logic              InputRead = 1'b0;
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              out_full;
    logic              out_overflow;
    logic              in_underflow;

    io_port_unit_if #(.DATA_W(DATA_W)) devIf ();

    io_port_unit #(.DATA_W(DATA_W), .OUT_DEPTH(4)) dut (
        .CLK          (CLK),
        .Reset        (Reset),
        .OutputWrite  (OutputWrite),
        .out_data     (out_data),
        .InputRead    (InputRead),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .out_full     (out_full),
        .out_overflow (out_overflow),
        .in_underflow (in_underflow),
        .devIf        (devIf)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;
    logic [DATA_W-1:0] outQ[$];
    logic [DATA_W-1:0] inQ[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic writeOut(input logic [DATA_W-1:0] d, input logic expectIt);
        OutputWrite = 1'b1;
        out_data    = d;
        if (expectIt) outQ.push_back(d);
        cyc();
        OutputWrite = 1'b0;
    endtask

    logic [DATA_W-1:0] wrapVec [9] = '{16'hBEEF, 16'hD001, 16'hD002, 16'hD003,
                                       16'hD004, 16'hD005, 16'hD006, 16'hD007, 16'hD008};

    initial begin
        devIf.ext_out_ready = 1'b0;
        devIf.ext_in_data   = '0;
        devIf.ext_in_valid  = 1'b0;

        fork
            // Monitor: compare every transfer against the scoreboard queues
            forever begin
                @(negedge CLK);
                if (!Reset && devIf.ext_out_valid && devIf.ext_out_ready) begin
                    if (outQ.size() == 0) begin
                        chk("out_unexpected", {16'h0, devIf.ext_out_data}, 32'hFFFF_FFFF);
                    end else begin
                        logic [DATA_W-1:0] e;
                        e = outQ.pop_front();
                        $display("OUT  word=%h expected=%h", devIf.ext_out_data, e);
                        chk("out_word", {16'h0, devIf.ext_out_data}, {16'h0, e});
                    end
                end
                if (!Reset && InputRead && in_valid) begin
                    if (inQ.size() == 0) begin
                        chk("in_unexpected", {16'h0, in_data}, 32'hFFFF_FFFF);
                    end else begin
                        logic [DATA_W-1:0] e;
                        e = inQ.pop_front();
                        $display("IN   word=%h expected=%h", in_data, e);
                        chk("in_word", {16'h0, in_data}, {16'h0, e});
                    end
                end
            end
            begin
                #200000;
                $display("FAIL watchdog actual=timeout required=finish");
                $fatal(1, "watchdog");
            end
        join_none

        // Reset state
        @(negedge CLK);
        chk("rst_in_ready", devIf.ext_in_ready, 1);
        chk("rst_outs", {in_data, in_valid, out_full, out_overflow, in_underflow,
                         devIf.ext_out_valid}, 0);
        chk("rst_out_data", devIf.ext_out_data, 0);
        @(posedge CLK); #1;
        Reset = 1'b0;
        cyc();

        // Three words, device ready from the following cycle
        OutputWrite = 1'b1; out_data = 16'h0011; outQ.push_back(16'h0011); cyc();
        devIf.ext_out_ready = 1'b1;
        out_data = 16'h0022; outQ.push_back(16'h0022); cyc();
        out_data = 16'h0033; outQ.push_back(16'h0033); cyc();
        OutputWrite = 1'b0;
        repeat (4) cyc();
        chk("drain3_valid", devIf.ext_out_valid, 0);
        devIf.ext_out_ready = 1'b0;

        // Fill to full, then one dropped write
        writeOut(16'hA001, 1'b1);
        writeOut(16'hA002, 1'b1);
        writeOut(16'hA003, 1'b1);
        chk("full_after3", out_full, 0);
        writeOut(16'hA004, 1'b1);
        chk("full_after4", out_full, 1);
        chk("ovf_before_drop", out_overflow, 0);
        writeOut(16'hA005, 1'b0);
        chk("ovf_after_drop", out_overflow, 1);
        chk("full_after_drop", out_full, 1);
        devIf.ext_out_ready = 1'b1;
        repeat (4) cyc();
        devIf.ext_out_ready = 1'b0;
        chk("drainA_valid", devIf.ext_out_valid, 0);
        chk("ovf_sticky", out_overflow, 1);

        // Asynchronous reset with two words held
        writeOut(16'h7701, 1'b0);
        writeOut(16'h7702, 1'b0);
        chk("pre_rst_valid", devIf.ext_out_valid, 1);
        Reset = 1'b1;
        #1;
        chk("async_rst_valid", devIf.ext_out_valid, 0);
        chk("async_rst_ovf", out_overflow, 0);
        chk("async_rst_data", devIf.ext_out_data, 0);
        cyc();
        Reset = 1'b0;
        cyc();

        // Push+pop while full, then keep going across pointer wrap
        writeOut(16'hC001, 1'b1);
        writeOut(16'hC002, 1'b1);
        writeOut(16'hC003, 1'b1);
        writeOut(16'hC004, 1'b1);
        chk("full_C", out_full, 1);
        devIf.ext_out_ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            writeOut(wrapVec[i], 1'b1);
            chk("full_pushpop", out_full, 1);
            chk("ovf_pushpop", out_overflow, 0);
        end
        repeat (5) cyc();
        devIf.ext_out_ready = 1'b0;
        chk("drainW_valid", devIf.ext_out_valid, 0);

        // Capture and consume one input word
        devIf.ext_in_valid = 1'b1; devIf.ext_in_data = 16'h1234; inQ.push_back(16'h1234);
        cyc();
        devIf.ext_in_valid = 1'b0;
        chk("cap_valid", in_valid, 1);
        chk("cap_data", in_data, 16'h1234);
        chk("cap_ready", devIf.ext_in_ready, 0);
        InputRead = 1'b1; cyc(); InputRead = 1'b0;
        chk("cons_valid", in_valid, 0);
        chk("cons_data", in_data, 0);
        chk("cons_ready", devIf.ext_in_ready, 1);
        chk("no_underflow", in_underflow, 0);

        // Underflow read in IN_EMPTY
        InputRead = 1'b1;
        @(negedge CLK);
        chk("uf_data", in_data, 0);
        @(posedge CLK); #1;
        InputRead = 1'b0;
        chk("uf_flag", in_underflow, 1);
        chk("uf_valid", in_valid, 0);

        // Consume while the device already offers the next word
        devIf.ext_in_valid = 1'b1; devIf.ext_in_data = 16'hAAAA; inQ.push_back(16'hAAAA);
        cyc();
        devIf.ext_in_data = 16'h5678;
        InputRead = 1'b1; cyc(); InputRead = 1'b0;
        chk("b2b_not_taken", in_valid, 0);
        chk("b2b_ready", devIf.ext_in_ready, 1);
        inQ.push_back(16'h5678);
        cyc();
        devIf.ext_in_valid = 1'b0;
        chk("b2b_valid", in_valid, 1);
        chk("b2b_data", in_data, 16'h5678);
        InputRead = 1'b1; cyc(); InputRead = 1'b0;
        chk("uf_sticky", in_underflow, 1);
        cyc();

        chk("outQ_empty", outQ.size(), 0);
        chk("inQ_empty", inQ.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
